// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - pattern modes, bar colours and 640x480@60 default timing
package video_timing_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_GRID  = 2'd3
    } mode_e;

    // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [7:0][23:0] BAR_COLOURS = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

endpackage

// File: rtl/video_pattern_gen.sv
// rtl/video_pattern_gen.sv - S1 to S2 colour generation with registered rgb
module video_pattern_gen
    import video_timing_pkg::*;
#(
    parameter int CW       = 12,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int CHK_LOG  = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  mode_e         mode_i,
    input  logic [CW-1:0] x_i,
    input  logic [CW-1:0] y_i,
    input  logic          de_i,
    input  logic [2:0]    bar_i,
    input  logic [23:0]   colour_i,
    output logic [23:0]   rgb_o
);

    logic [23:0] w_rgb;
    logic        w_grid_hit;

    assign w_grid_hit = (x_i[5:0] == 6'd0) || (y_i[5:0] == 6'd0) ||
                        (x_i == CW'(H_ACTIVE - 1)) || (y_i == CW'(V_ACTIVE - 1));

    always_comb begin
        w_rgb = 24'h000000;
        if (de_i) begin
            case (mode_i)
                MODE_SOLID: w_rgb = colour_i;
                MODE_BARS:  w_rgb = BAR_COLOURS[bar_i];
                MODE_CHECK: w_rgb = (x_i[CHK_LOG] ^ y_i[CHK_LOG]) ? 24'hFFFFFF : 24'h000000;
                MODE_GRID:  w_rgb = w_grid_hit ? 24'hFFFFFF : 24'h000000;
                default:    w_rgb = 24'h000000;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_o <= 24'h000000;
        end else if (en_i) begin
            rgb_o <= w_rgb;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster counters, sync decode, mode latch and output pipeline
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CW       = 12,
    parameter int CHK_LOG  = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic [1:0]    mode_i,
    input  logic [23:0]   colour_i,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          de_o,
    output logic [CW-1:0] x_o,
    output logic [CW-1:0] y_o,
    output logic          frame_start_o,
    output logic [7:0]    red_o,
    output logic [7:0]    green_o,
    output logic [7:0]    blue_o
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int BAR_W    = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    // S0: counters, mode latch and a running bar index that avoids an x/BAR_W divider
    logic [CW-1:0] r_h;
    logic [CW-1:0] r_v;
    logic [CW-1:0] r_bar_px;
    logic [2:0]    r_bar_idx;
    mode_e         r_mode;
    logic          w_h_last;
    logic          w_v_last;

    assign w_h_last = (r_h == CW'(H_TOTAL - 1));
    assign w_v_last = (r_v == CW'(V_TOTAL - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h       <= '0;
            r_v       <= '0;
            r_bar_px  <= '0;
            r_bar_idx <= 3'd0;
            r_mode    <= MODE_SOLID;
        end else if (en_i) begin
            if (w_h_last) begin
                r_h       <= '0;
                r_bar_px  <= '0;
                r_bar_idx <= 3'd0;
                if (w_v_last) begin
                    r_v    <= '0;
                    r_mode <= mode_e'(mode_i);
                end else begin
                    r_v <= r_v + CW'(1);
                end
            end else begin
                r_h <= r_h + CW'(1);
                if (r_bar_px == CW'(BAR_W - 1)) begin
                    r_bar_px <= '0;
                    if (r_bar_idx != 3'd7) begin
                        r_bar_idx <= r_bar_idx + 3'd1;
                    end
                end else begin
                    r_bar_px <= r_bar_px + CW'(1);
                end
            end
        end
    end

    // S1: registered decode
    logic          r1_de;
    logic          r1_hs;
    logic          r1_vs;
    logic          r1_fs;
    logic [CW-1:0] r1_x;
    logic [CW-1:0] r1_y;
    logic [2:0]    r1_bar;
    mode_e         r1_mode;
    logic          w_hs_act;
    logic          w_vs_act;

    assign w_hs_act = (r_h >= CW'(HS_START)) && (r_h < CW'(HS_END));
    assign w_vs_act = (r_v >= CW'(VS_START)) && (r_v < CW'(VS_END));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_de   <= 1'b0;
            r1_hs   <= ~HS_POL;
            r1_vs   <= ~VS_POL;
            r1_fs   <= 1'b0;
            r1_x    <= '0;
            r1_y    <= '0;
            r1_bar  <= 3'd0;
            r1_mode <= MODE_SOLID;
        end else if (en_i) begin
            r1_de   <= (r_h < CW'(H_ACTIVE)) && (r_v < CW'(V_ACTIVE));
            r1_hs   <= w_hs_act ? HS_POL : ~HS_POL;
            r1_vs   <= w_vs_act ? VS_POL : ~VS_POL;
            r1_fs   <= (r_h == '0) && (r_v == '0);
            r1_x    <= r_h;
            r1_y    <= r_v;
            r1_bar  <= r_bar_idx;
            r1_mode <= r_mode;
        end
    end

    // S2: timing outputs, aligned with the registered rgb from the pattern generator
    logic          r2_de;
    logic          r2_hs;
    logic          r2_vs;
    logic          r2_fs;
    logic [CW-1:0] r2_x;
    logic [CW-1:0] r2_y;
    logic [23:0]   w_rgb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_de <= 1'b0;
            r2_hs <= ~HS_POL;
            r2_vs <= ~VS_POL;
            r2_fs <= 1'b0;
            r2_x  <= '0;
            r2_y  <= '0;
        end else if (en_i) begin
            r2_de <= r1_de;
            r2_hs <= r1_hs;
            r2_vs <= r1_vs;
            r2_fs <= r1_fs;
            r2_x  <= r1_x;
            r2_y  <= r1_y;
        end
    end

    video_pattern_gen #(
        .CW       (CW),
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .CHK_LOG  (CHK_LOG)
    ) u_pattern (
        .clk      (clk),
        .rst      (rst),
        .en_i     (en_i),
        .mode_i   (r1_mode),
        .x_i      (r1_x),
        .y_i      (r1_y),
        .de_i     (r1_de),
        .bar_i    (r1_bar),
        .colour_i (colour_i),
        .rgb_o    (w_rgb)
    );

    assign hsync_o       = r2_hs;
    assign vsync_o       = r2_vs;
    assign de_o          = r2_de;
    assign x_o           = r2_x;
    assign y_o           = r2_y;
    assign frame_start_o = r2_fs;
    assign {red_o, green_o, blue_o} = w_rgb;

endmodule
